// File: rtl/axis_dsrc_if.sv
// AXI-Stream bus bundle between the pattern source and its downstream sink.
interface axis_dsrc_if #(
    parameter int unsigned NB = 4
) ();
    logic              TVALID;
    logic              TREADY;
    logic [8*NB-1:0]   TDATA;
    logic [NB-1:0]     TSTRB;
    logic              TLAST;

    modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/axis_dsrc.sv
// Command-driven AXI-Stream pattern source with byte count and additive checksum
// matching the sink's accounting rules.
module axis_dsrc #(
    parameter int unsigned C_M_AXIS_TDATA_NUM_BYTES = 4
) (
    input  logic                                    AXIS_ACLK,
    input  logic                                    AXIS_ARESETN,
    axis_dsrc_if.master                             M_AXIS,
    input  logic [31:0]                             cmd,
    input  logic                                    new_cmd,
    input  logic [31:0]                             len_words,
    input  logic [15:0]                             pkt_words,
    input  logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0]   seed,
    output logic [31:0]                             stat,
    output logic [31:0]                             sent_bytes,
    output logic [63:0]                             checksum
);
    localparam int unsigned NB = C_M_AXIS_TDATA_NUM_BYTES;
    localparam int unsigned W  = 8 * NB;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_done, w_done_nxt;
    logic           r_aborted, w_aborted_nxt;
    logic [31:0]    r_len;
    logic [15:0]    r_pkt;
    logic           r_mode;
    logic [W-1:0]   r_data;
    logic [31:0]    r_beat;
    logic [15:0]    r_pidx;
    logic           r_last;
    logic           r_abort_pend;
    logic [31:0]    r_sent;
    logic [63:0]    r_sum;

    logic           w_start, w_stop, w_clear, w_hs, w_end, w_launch;
    logic [31:0]    w_beat_nxt;
    logic [15:0]    w_pidx_nxt;
    logic           w_last_nxt;
    logic           w_unused_cmd;

    assign w_start      = new_cmd & (cmd[1:0] == 2'b01);
    assign w_stop       = new_cmd & (cmd[1:0] == 2'b10);
    assign w_clear      = new_cmd & (cmd[1:0] == 2'b11);
    assign w_unused_cmd = ^{cmd[31:5], cmd[3:2]};
    assign w_hs         = r_valid & M_AXIS.TREADY;
    assign w_launch     = w_start & (r_state != S_RUN);
    // A stop coinciding with a handshake makes that handshake the last one.
    assign w_end        = w_hs & ((r_beat == r_len - 32'd1) | r_abort_pend | w_stop);

    // Counters for the beat presented after the current one is accepted.
    assign w_beat_nxt = r_beat + 32'd1;
    assign w_pidx_nxt = r_last ? 16'd0 : r_pidx + 16'd1;
    assign w_last_nxt = (w_beat_nxt == r_len - 32'd1) |
                        ((r_pkt != 16'd0) & (w_pidx_nxt == r_pkt - 16'd1));

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_valid;
        w_done_nxt    = r_done;
        w_aborted_nxt = r_aborted;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_aborted_nxt = 1'b0;
                    if (len_words == 32'd0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_done_nxt  = 1'b0;
                        w_valid_nxt = 1'b1;
                    end
                end else if (w_clear) begin
                    w_state_nxt   = S_IDLE;
                    w_done_nxt    = 1'b0;
                    w_aborted_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (w_end) begin
                    w_state_nxt   = S_DONE;
                    w_valid_nxt   = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = r_abort_pend | w_stop;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Pattern generator and accounting datapath.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_len        <= '0;
            r_pkt        <= '0;
            r_mode       <= 1'b0;
            r_data       <= '0;
            r_beat       <= '0;
            r_pidx       <= '0;
            r_last       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_sent       <= '0;
            r_sum        <= '0;
        end else if (w_launch) begin
            r_len        <= len_words;
            r_pkt        <= pkt_words;
            r_mode       <= cmd[4];
            r_data       <= seed;
            r_beat       <= '0;
            r_pidx       <= '0;
            r_last       <= (len_words == 32'd1) | (pkt_words == 16'd1);
            r_abort_pend <= 1'b0;
            r_sent       <= '0;
            r_sum        <= '0;
        end else if (w_clear && r_state != S_RUN) begin
            r_sent <= '0;
            r_sum  <= '0;
        end else if (r_state == S_RUN) begin
            if (w_stop)
                r_abort_pend <= 1'b1;
            if (w_hs) begin
                r_sent <= r_sent + 32'(NB);
                r_sum  <= r_sum + 64'(r_data);
                if (!w_end) begin
                    r_data <= r_mode ? r_data : r_data + W'(1);
                    r_beat <= w_beat_nxt;
                    r_pidx <= w_pidx_nxt;
                    r_last <= w_last_nxt;
                end
            end
        end
    end

    assign M_AXIS.TVALID = r_valid;
    assign M_AXIS.TDATA  = r_data;
    assign M_AXIS.TLAST  = r_last;
    assign M_AXIS.TSTRB  = {NB{r_valid}};
    assign stat          = {29'd0, r_aborted, r_done, r_valid};
    assign sent_bytes    = r_sent;
    assign checksum      = r_sum;
endmodule

// File: tb/tb_axis_dsrc.sv
// Scoreboard bench for axis_dsrc: the driver queues model beats per transfer,
// a negedge monitor pops and compares every presented beat.
module tb_axis_dsrc;
    localparam int unsigned NB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd = '0;
    logic        new_cmd = 1'b0;
    logic [31:0] len_words = '0;
    logic [15:0] pkt_words = '0;
    logic [31:0] seed = '0;
    logic [31:0] stat, sent_bytes;
    logic [63:0] checksum;

    always #5 clk = ~clk;

    axis_dsrc_if #(.NB(NB)) m_axis ();

    axis_dsrc #(.C_M_AXIS_TDATA_NUM_BYTES(NB)) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (rst_n),
        .M_AXIS       (m_axis),
        .cmd          (cmd),
        .new_cmd      (new_cmd),
        .len_words    (len_words),
        .pkt_words    (pkt_words),
        .seed         (seed),
        .stat         (stat),
        .sent_bytes   (sent_bytes),
        .checksum     (checksum)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    hs_cnt = 0;
    logic  stalled = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle is checked against the head of the expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (m_axis.TVALID) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_beat: got tvalid with data 0x%0h, expected no beat", m_axis.TDATA);
            end else begin
                e = exp_q[0];
                check(m_axis.TREADY ? "tdata" : "hold_tdata", 64'(m_axis.TDATA), 64'(e.data));
                check(m_axis.TREADY ? "tlast" : "hold_tlast", 64'(m_axis.TLAST), 64'(e.last));
                if (m_axis.TREADY) begin
                    check("tstrb", 64'(m_axis.TSTRB), 64'hF);
                    void'(exp_q.pop_front());
                end
            end
            if (m_axis.TREADY)
                hs_cnt++;
            stalled = !m_axis.TREADY;
        end else begin
            if (stalled) begin
                n_vec++;
                n_err++;
                $display("FAIL withdrawn: got tvalid 0, expected 1 until accepted");
            end
            stalled = 1'b0;
        end
    end

    task automatic run_xfer(input string tag, input logic [31:0] sd, input bit mode,
                            input int len, input int pkt, input bit rnd, input int stop_at);
        int          n;
        int          base;
        int          hold;
        int          cyc;
        bit          issued;
        bit          done_seen;
        logic [63:0] sum;
        logic [31:0] d;
        beat_t       b;

        n = (stop_at >= 0) ? stop_at + 1 : len;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            d = mode ? sd : sd + 32'(k);
            b.data = d;
            b.last = (k == len - 1) || (pkt != 0 && (k % pkt) == pkt - 1);
            exp_q.push_back(b);
            sum += 64'(d);
        end

        base = hs_cnt;
        issued = 1'b0;
        done_seen = 1'b0;
        hold = 0;
        cyc = 0;
        @(posedge clk); #1;
        cmd       = (32'(mode) << 4) | 32'h1;
        len_words = 32'(len);
        pkt_words = 16'(pkt);
        seed      = sd;
        new_cmd   = 1'b1;
        m_axis.TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            new_cmd = 1'b0;
            if (stat[1]) begin
                done_seen = 1'b1;
                cyc = c;
                break;
            end
            if (stop_at >= 0 && !issued && (hs_cnt - base) == stop_at) begin
                m_axis.TREADY = 1'b0;
                cmd = 32'h2;
                new_cmd = 1'b1;
                issued = 1'b1;
                hold = 2;
            end else if (hold > 0) begin
                m_axis.TREADY = 1'b0;
                hold--;
            end else begin
                m_axis.TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!done_seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done within 2000 cycles, expected done", tag);
        end
        m_axis.TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_handshakes"}, 64'(hs_cnt - base), 64'(n));
        check({tag, "_sent_bytes"}, 64'(sent_bytes), 64'(n * NB));
        check({tag, "_checksum"}, checksum, sum);
        check({tag, "_stat"}, 64'(stat), (stop_at >= 0) ? 64'h6 : 64'h2);
        if (!rnd && stop_at < 0 && len > 0)
            check({tag, "_cycles"}, 64'(cyc), 64'(len));
        exp_q.delete();
    endtask

    initial begin
        int          len;
        int          stop_at;
        logic [31:0] sd;

        m_axis.TREADY = 1'b0;
        #12;
        check("rst_tvalid", 64'(m_axis.TVALID), 64'd0);
        check("rst_tstrb", 64'(m_axis.TSTRB), 64'd0);
        check("rst_stat", 64'(stat), 64'd0);
        check("rst_sent_bytes", 64'(sent_bytes), 64'd0);
        check("rst_checksum", checksum, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_xfer("basic", 32'h0, 1'b0, 4, 0, 1'b0, -1);
        run_xfer("packet", 32'h0, 1'b0, 10, 4, 1'b0, -1);
        run_xfer("backpressure", 32'h0, 1'b0, 8, 0, 1'b1, -1);
        run_xfer("wrap", 32'hFFFF_FFFE, 1'b0, 3, 0, 1'b0, -1);
        run_xfer("const", 32'hA5A5_0001, 1'b1, 5, 2, 1'b1, -1);
        run_xfer("stop", 32'h0, 1'b0, 12, 0, 1'b1, 5);

        @(posedge clk); #1;
        cmd = 32'h3;
        new_cmd = 1'b1;
        @(posedge clk); #1;
        new_cmd = 1'b0;
        check("clear_stat", 64'(stat), 64'd0);
        check("clear_sent_bytes", 64'(sent_bytes), 64'd0);
        check("clear_checksum", checksum, 64'd0);

        run_xfer("len0", 32'h1234, 1'b0, 0, 0, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            sd = $urandom;
            len = $urandom_range(1, 24);
            stop_at = (len > 2 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 2) : -1;
            run_xfer("random", sd, 1'($urandom_range(0, 1)), len, $urandom_range(0, 5), 1'b1, stop_at);
        end

        // Reset in the middle of a long transfer must clear outputs before the next edge.
        begin
            beat_t b;
            for (int k = 0; k < 20; k++) begin
                b.data = 32'h100 + 32'(k);
                b.last = (k == 19);
                exp_q.push_back(b);
            end
        end
        @(posedge clk); #1;
        cmd = 32'h1;
        len_words = 32'd20;
        pkt_words = 16'd0;
        seed = 32'h100;
        new_cmd = 1'b1;
        m_axis.TREADY = 1'b1;
        @(posedge clk); #1;
        new_cmd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(stat), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis.TVALID), 64'd0);
        check("mid_rst_sent_bytes", 64'(sent_bytes), 64'd0);
        check("mid_rst_checksum", checksum, 64'd0);
        check("mid_rst_stat", 64'(stat), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_tvalid", 64'(m_axis.TVALID), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
